// File: rtl/softmax_stream_tx.sv
// Buffers one vector of up to 2**INPUTMAX words from a valid/ready stream, then
// pulses Start and replays the words back-to-back to a softmax consumer.
module softmax_stream_tx #(
  parameter int BITWIDTH = 32,
  parameter int INPUTMAX = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                In_valid,
  input  logic [BITWIDTH-1:0] In_data,
  input  logic                In_last,
  output logic                In_ready,
  output logic                Start,
  output logic [BITWIDTH-1:0] Datain,
  output logic [INPUTMAX:0]   N,
  input  logic                Rearm,
  output logic                Busy
);

  localparam int D = 2**INPUTMAX;
  localparam logic [INPUTMAX:0] LAST_IDX = (INPUTMAX+1)'(D-1);

  typedef enum logic [1:0] {FILL, START, STREAM, WAIT} state_t;

  state_t                state_q, state_d;
  logic [INPUTMAX:0]     wcnt_q, wcnt_d;
  logic [INPUTMAX:0]     rcnt_q, rcnt_d;
  logic [INPUTMAX:0]     n_q, n_d;
  logic [BITWIDTH-1:0]   buf_q [D];
  logic                  accept;

  assign accept = !Reset && (state_q == FILL) && In_valid;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= FILL;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      n_q     <= n_d;
    end
  end

  // Storage is deliberately not reset; stale words are never read back.
  always_ff @(posedge Clock) begin
    if (accept) buf_q[wcnt_q[INPUTMAX-1:0]] <= In_data;
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    n_d     = n_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          wcnt_d = wcnt_q + 1'b1;
          // A full buffer closes the vector even without In_last.
          if (In_last || (wcnt_q == LAST_IDX)) begin
            state_d = START;
            n_d     = wcnt_q;
            wcnt_d  = '0;
          end
        end
      end
      START: begin
        state_d = STREAM;
        rcnt_d  = '0;
      end
      STREAM: begin
        if (rcnt_q == n_q) begin
          state_d = WAIT;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (Rearm) begin
          state_d = FILL;
          wcnt_d  = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Outputs are forced quiet while Reset is high, whatever the state.
  always_comb begin
    In_ready = !Reset && (state_q == FILL);
    Start    = !Reset && (state_q == START);
    Busy     = !Reset && (state_q != FILL);
    N        = Reset ? '0 : n_q;
    Datain   = (!Reset && (state_q == STREAM)) ? buf_q[rcnt_q[INPUTMAX-1:0]] : '0;
  end

endmodule

// File: tb/tb_softmax_stream_tx.sv
// Directed bench for softmax_stream_tx: fill, stream, wait/rearm, overflow and reset abort.
module tb_softmax_stream_tx;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        In_valid;
  logic [31:0] In_data;
  logic        In_last;
  logic        In_ready;
  logic        Start;
  logic [31:0] Datain;
  logic [2:0]  N;
  logic        Rearm;
  logic        Busy;

  int checks = 0;
  int errors = 0;

  softmax_stream_tx #(.BITWIDTH(32), .INPUTMAX(2)) dut (
    .Clock(Clock), .Reset(Reset), .In_valid(In_valid), .In_data(In_data),
    .In_last(In_last), .In_ready(In_ready), .Start(Start), .Datain(Datain),
    .N(N), .Rearm(Rearm), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One accepted word; leaves the bench settled in the following cycle with inputs idle.
  task automatic push(input logic [31:0] d, input logic l);
    In_valid = 1'b1; In_data = d; In_last = l;
    tick();
    In_valid = 1'b0; In_last = 1'b0;
    #1;
  endtask

  // Called settled in the START cycle; ends settled in the first WAIT cycle.
  task automatic expect_vec(input string tag, input logic [31:0] w [4], input int n);
    chk({tag, ".start"}, Start, 1);
    chk({tag, ".n"}, N, n);
    chk({tag, ".rdy_start"}, In_ready, 0);
    chk({tag, ".busy_start"}, Busy, 1);
    for (int k = 0; k <= n; k++) begin
      tick(); #1;
      chk($sformatf("%s.d%0d", tag, k), Datain, w[k]);
      chk($sformatf("%s.nostart%0d", tag, k), Start, 0);
      chk($sformatf("%s.rdy%0d", tag, k), In_ready, 0);
    end
    tick(); #1;
    chk({tag, ".wait_d"}, Datain, 0);
    chk({tag, ".wait_busy"}, Busy, 1);
    chk({tag, ".wait_n"}, N, n);
  endtask

  task automatic rearm(input string tag);
    Rearm = 1'b1;
    tick();
    Rearm = 1'b0;
    #1;
    chk({tag, ".rdy"}, In_ready, 1);
    chk({tag, ".busy"}, Busy, 0);
  endtask

  logic [31:0] w [4];

  initial begin
    Reset = 1'b1; In_valid = 1'b0; In_data = '0; In_last = 1'b0; Rearm = 1'b0;

    // reset state
    tick(); tick(); #1;
    chk("rst.rdy", In_ready, 0);
    chk("rst.busy", Busy, 0);
    chk("rst.start", Start, 0);
    chk("rst.d", Datain, 0);
    chk("rst.n", N, 0);
    tick();
    Reset = 1'b0; #1;
    chk("rst.rdy_after", In_ready, 1);

    // three-word vector
    push(32'h3F800000, 0);
    chk("v3.rdy_mid", In_ready, 1);
    chk("v3.nostart_mid", Start, 0);
    push(32'h40000000, 0);
    push(32'h40400000, 1);
    w = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h0};
    expect_vec("v3", w, 2);
    rearm("v3.rearm");

    // overflow: five words, no In_last; fifth stays pending through the stream
    push(32'hA0, 0); push(32'hA1, 0); push(32'hA2, 0); push(32'hA3, 0);
    In_valid = 1'b1; In_data = 32'hA4; #1;
    w = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    expect_vec("ovf", w, 3);
    tick(); #1;
    chk("ovf.hold_rdy", In_ready, 0);
    chk("ovf.hold_busy", Busy, 1);
    rearm("ovf.rearm");
    tick();                       // A4 accepted as word 0
    In_data = 32'hA5; In_last = 1'b1;
    tick();
    In_valid = 1'b0; In_last = 1'b0; #1;
    w = '{32'hA4, 32'hA5, 32'h0, 32'h0};
    expect_vec("ovf2", w, 1);
    rearm("ovf2.rearm");

    // single word
    push(32'h12345678, 1);
    w = '{32'h12345678, 32'h0, 32'h0, 32'h0};
    expect_vec("one", w, 0);
    rearm("one.rearm");

    // gapped valid; In_last with In_valid low is ignored
    push(32'hB0, 0);
    In_valid = 1'b0; In_last = 1'b1; In_data = 32'hDEAD;
    tick(); #1;
    chk("gap.nostart", Start, 0);
    chk("gap.rdy", In_ready, 1);
    push(32'hB1, 1);
    w = '{32'hB0, 32'hB1, 32'h0, 32'h0};
    expect_vec("gap", w, 1);
    rearm("gap.rearm");

    // reset mid-stream
    push(32'hC0, 0); push(32'hC1, 0); push(32'hC2, 0); push(32'hC3, 1);
    chk("rs.start", Start, 1);
    tick(); #1;
    chk("rs.d0", Datain, 32'hC0);
    tick();
    Reset = 1'b1; #1;
    chk("rs.d_rst", Datain, 0);
    chk("rs.busy_rst", Busy, 0);
    chk("rs.rdy_rst", In_ready, 0);
    chk("rs.n_rst", N, 0);
    tick();
    Reset = 1'b0; #1;
    chk("rs.rdy_after", In_ready, 1);
    chk("rs.d_after", Datain, 0);
    chk("rs.n_after", N, 0);
    chk("rs.busy_after", Busy, 0);
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      chk($sformatf("rs.nostart%0d", i), Start, 0);
    end

    // Rearm during STREAM must not shorten the stream or skip WAIT
    push(32'hE0, 0);
    push(32'hE1, 1);
    Rearm = 1'b1; #1;
    w = '{32'hE0, 32'hE1, 32'h0, 32'h0};
    expect_vec("rar", w, 1);
    Rearm = 1'b0;
    tick(); #1;
    chk("rar.wait1", Busy, 1);
    tick(); #1;
    chk("rar.wait2", In_ready, 0);
    rearm("rar.rearm");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout got 0 exp 1");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
